// File: rtl/fifo_uart_tx.sv
// Purpose: drains words from an upstream FIFO and sends each as an 8N1-style UART frame (start, word_length data bits LSB first, stop).
// Latency: 1 cycle IDLE->POP, 1 POP cycle, read_latency WAIT cycles, then (word_length+2)*clks_per_bit cycles of frame.
// Backpressure: a word is requested only when Empty is low in IDLE or at the end of STOP; one Pop per frame, never while a frame is in flight.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-low reset
//   Empty  - upstream FIFO has no words
//   DataIn - upstream FIFO read data, valid read_latency cycles after Pop
//   Pop    - one-cycle read request to the FIFO
//   Tx     - serial line, idle high, registered
//   Busy   - high whenever the state machine is not IDLE
module fifo_uart_tx #(
    parameter int word_length  = 8,
    parameter int read_latency = 2,
    parameter int clks_per_bit = 434    // must be >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Empty,
    input  logic [word_length-1:0] DataIn,
    output logic                   Pop,
    output logic                   Tx,
    output logic                   Busy
);

    localparam int BAUD_W = $clog2(clks_per_bit);
    localparam int BIT_W  = $clog2(word_length) + 1;
    localparam int WAIT_W = $clog2(read_latency + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(word_length - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(read_latency);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_nxt;
    logic [BAUD_W-1:0]      baud_cnt, baud_nxt;
    logic [BIT_W-1:0]       bit_cnt, bit_nxt;
    logic [WAIT_W-1:0]      wait_cnt, wait_nxt;
    logic [word_length-1:0] shift_reg, shift_nxt;
    logic                   tx_nxt;

    // Pop and Busy are pure decodes of the state register, so reset clears
    // them immediately along with the state.
    assign Pop  = (state == POP);
    assign Busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        wait_nxt  = wait_cnt;
        shift_nxt = shift_reg;

        case (state)
            IDLE: begin
                if (!Empty) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                // The first WAIT cycle is one cycle after Pop.
                state_nxt = WAIT;
                wait_nxt  = WAIT_W'(1);
            end
            WAIT: begin
                // DataIn is valid in the cycle read_latency after Pop; capture it
                // on that cycle's closing edge.
                if (wait_cnt == WAIT_LAST) begin
                    shift_nxt = DataIn;
                    wait_nxt  = '0;
                    baud_nxt  = '0;
                    state_nxt = START;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                // Going straight to POP keeps back-to-back frames free of an
                // extra idle bit; only the POP/WAIT cycles separate them.
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = Empty ? IDLE : POP;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Tx is registered from the value the line must carry in the next
        // state, so it changes on the same edge as the state and never glitches.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            shift_reg <= '0;
            Tx        <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            wait_cnt  <= wait_nxt;
            shift_reg <= shift_nxt;
            Tx        <= tx_nxt;
        end
    end

endmodule
